if_id_fetch_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register. It owns the PC, drives the instruction-memory address
//   and registers the fetched word. It also pre-decodes imm16/ExtOp so the immediate extender in ID sees stable

---
 rtl/if_id_fetch_stage.sv | 124 ++++++++++++
 tb/tb_if_id_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word, its PC, link address and immediate pre-decode.
module if_id_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [15:0] id_imm16,
  output logic        id_extop,
  output logic        id_valid,
  output logic        id_adel
);

  // Range limits held at 33 bits so a memory ending at 2^32 still compares correctly.
  localparam logic [32:0] PC_LO = {1'b0, PC_RESET};
  localparam logic [32:0] PC_HI = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc8_reg, id_pc8_next;
  logic [15:0] imm16_reg, imm16_next;
  logic        extop_reg, extop_next;
  logic        valid_reg, valid_next;
  logic        adel_reg, adel_next;

  logic        fetch_err;
  logic [31:0] fetch_word;
  logic        fetch_extop;

  assign fetch_err = (pc_reg[1:0] != 2'b00)
                   | ({1'b0, pc_reg} < PC_LO)
                   | ({1'b0, pc_reg} >= PC_HI);

  assign fetch_word = fetch_err ? 32'h0 : im_rdata;

  // Opcodes whose 16-bit immediate is signed: arithmetic/compare, branches, loads/stores.
  always_comb begin
    fetch_extop = 1'b0;
    case (fetch_word[31:26])
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001,
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: fetch_extop = 1'b1;
      default:                         fetch_extop = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (!stall) begin
      pc_next = redirect ? redirect_pc : pc_reg + 32'd4;
    end
  end

  always_comb begin
    instr_next  = instr_reg;
    id_pc_next  = id_pc_reg;
    id_pc8_next = id_pc8_reg;
    imm16_next  = imm16_reg;
    extop_next  = extop_reg;
    valid_next  = valid_reg;
    adel_next   = adel_reg;
    if (flush) begin
      instr_next  = 32'h0;
      id_pc_next  = pc_reg;
      id_pc8_next = pc_reg + 32'd8;
      imm16_next  = 16'h0;
      extop_next  = 1'b0;
      valid_next  = 1'b0;
      adel_next   = 1'b0;
    end else if (!stall) begin
      instr_next  = fetch_word;
      id_pc_next  = pc_reg;
      id_pc8_next = pc_reg + 32'd8;
      imm16_next  = fetch_word[15:0];
      extop_next  = fetch_extop;
      valid_next  = 1'b1;
      adel_next   = fetch_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= PC_RESET;
      instr_reg  <= 32'h0;
      id_pc_reg  <= 32'h0;
      id_pc8_reg <= 32'h0;
      imm16_reg  <= 16'h0;
      extop_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      adel_reg   <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      id_pc_reg  <= id_pc_next;
      id_pc8_reg <= id_pc8_next;
      imm16_reg  <= imm16_next;
      extop_reg  <= extop_next;
      valid_reg  <= valid_next;
      adel_reg   <= adel_next;
    end
  end

  assign im_addr  = pc_reg;
  assign id_instr = instr_reg;
  assign id_pc    = id_pc_reg;
  assign id_pc8   = id_pc8_reg;
  assign id_imm16 = imm16_reg;
  assign id_extop = extop_reg;
  assign id_valid = valid_reg;
  assign id_adel  = adel_reg;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: word-index instruction memory with an
// override word, hand-computed expectations for each edge.
module tb_if_id_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic [15:0] id_imm16;
  logic        id_extop;
  logic        id_valid;
  logic        id_adel;

  logic        ovr_en;
  logic [31:0] ovr_word;

  int checks;
  int failures;

  if_id_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_rdata(im_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_imm16(id_imm16), .id_extop(id_extop), .id_valid(id_valid), .id_adel(id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the word index relative to 0x3000 unless an override is active.
  assign im_rdata = ovr_en ? ovr_word : ((im_addr - 32'h3000) >> 2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("check %s got=%08h ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic [31:0] addr);
    check({tag, ".id_pc"}, id_pc, pc);
    check({tag, ".id_pc8"}, id_pc8, pc + 32'd8);
    check({tag, ".id_instr"}, id_instr, instr);
    check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, valid});
    check({tag, ".im_addr"}, im_addr, addr);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ovr_en = 1'b0; ovr_word = 32'h0;

    // Reset state
    step(); step();
    check("rst.im_addr", im_addr, 32'h3000);
    check("rst.id_pc", id_pc, 32'h0);
    check("rst.id_pc8", id_pc8, 32'h0);
    check("rst.id_instr", id_instr, 32'h0);
    check("rst.id_valid", {31'b0, id_valid}, 32'h0);
    check("rst.id_adel", {31'b0, id_adel}, 32'h0);
    reset = 1'b0;

    // Sequential fetch
    step(); check_id("seq0", 32'h3000, 32'h0, 1'b1, 32'h3004);
    step(); check_id("seq1", 32'h3004, 32'h1, 1'b1, 32'h3008);
    step(); check_id("seq2", 32'h3008, 32'h2, 1'b1, 32'h300C);
    step(); check_id("seq3", 32'h300C, 32'h3, 1'b1, 32'h3010);

    // Stall three cycles at 0x3010
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_id("stall", 32'h300C, 32'h3, 1'b1, 32'h3010);
    end
    stall = 1'b0;
    step(); check_id("rel0", 32'h3010, 32'h4, 1'b1, 32'h3014);
    step(); check_id("rel1", 32'h3014, 32'h5, 1'b1, 32'h3018);

    // Immediate / ExtOp pre-decode
    ovr_en = 1'b1; ovr_word = 32'h2008FFFF;
    step();
    check("addi.instr", id_instr, 32'h2008FFFF);
    check("addi.imm16", {16'h0, id_imm16}, 32'hFFFF);
    check("addi.extop", {31'b0, id_extop}, 32'h1);
    ovr_word = 32'h3408FFFF;
    step();
    check("ori.imm16", {16'h0, id_imm16}, 32'hFFFF);
    check("ori.extop", {31'b0, id_extop}, 32'h0);
    ovr_word = 32'h3C08000A;
    step();
    check("lui.imm16", {16'h0, id_imm16}, 32'h000A);
    check("lui.extop", {31'b0, id_extop}, 32'h0);
    ovr_word = 32'h8C080004;
    step();
    check("lw.extop", {31'b0, id_extop}, 32'h1);
    check("lw.id_pc", id_pc, 32'h3024);
    ovr_en = 1'b0;

    // Redirect keeps the delay-slot instruction
    redirect = 1'b1; redirect_pc = 32'h3100;
    step(); check_id("redir", 32'h3028, 32'hA, 1'b1, 32'h3100);
    redirect_pc = 32'h3200; stall = 1'b1;
    step(); check_id("redir_stall", 32'h3028, 32'hA, 1'b1, 32'h3100);
    redirect = 1'b0; stall = 1'b0;
    step(); check_id("redir_tgt", 32'h3100, 32'h40, 1'b1, 32'h3104);

    // Flush beats stall
    flush = 1'b1; stall = 1'b1;
    step(); check_id("flush_stall", 32'h3104, 32'h0, 1'b0, 32'h3104);
    flush = 1'b0; stall = 1'b0;

    // Address errors
    ovr_en = 1'b1; ovr_word = 32'hDEADBEEF;
    redirect = 1'b1; redirect_pc = 32'h3002;
    step(); check_id("pre_mis", 32'h3104, 32'hDEADBEEF, 1'b1, 32'h3002);
    redirect_pc = 32'h4000;
    step();
    check("mis.id_pc", id_pc, 32'h3002);
    check("mis.adel", {31'b0, id_adel}, 32'h1);
    check("mis.instr", id_instr, 32'h0);
    redirect_pc = 32'h3FFC;
    step();
    check("hi.id_pc", id_pc, 32'h4000);
    check("hi.adel", {31'b0, id_adel}, 32'h1);
    check("hi.instr", id_instr, 32'h0);
    redirect_pc = 32'h2FFC;
    step();
    check("last.id_pc", id_pc, 32'h3FFC);
    check("last.adel", {31'b0, id_adel}, 32'h0);
    check("last.instr", id_instr, 32'hDEADBEEF);
    redirect_pc = 32'hFFFFFFFC;
    step();
    check("lo.id_pc", id_pc, 32'h2FFC);
    check("lo.adel", {31'b0, id_adel}, 32'h1);
    check("wrap.im_addr0", im_addr, 32'hFFFFFFFC);
    redirect = 1'b0;
    step();
    check("wrap.im_addr1", im_addr, 32'h0);
    ovr_en = 1'b0;

    // Asynchronous reset mid-operation
    redirect = 1'b1; redirect_pc = 32'h3020;
    step(); redirect = 1'b0;
    step(); check_id("pre_rst", 32'h3020, 32'h8, 1'b1, 32'h3024);
    #2 reset = 1'b1;
    #1;
    check("arst.im_addr", im_addr, 32'h3000);
    check("arst.id_pc", id_pc, 32'h0);
    check("arst.id_pc8", id_pc8, 32'h0);
    check("arst.id_instr", id_instr, 32'h0);
    check("arst.id_valid", {31'b0, id_valid}, 32'h0);
    step(); reset = 1'b0;
    check("post_rst.im_addr", im_addr, 32'h3000);
    step(); check_id("post_rst", 32'h3000, 32'h0, 1'b1, 32'h3004);

    // Flush without stall: bubble, PC keeps advancing
    flush = 1'b1;
    step(); check_id("flush", 32'h3004, 32'h0, 1'b0, 32'h3008);
    flush = 1'b0;
    step(); check_id("after_flush", 32'h3008, 32'h2, 1'b1, 32'h300C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
